// File: rtl/csa916_sequencer.sv
// csa916_sequencer: buffers up to nine 16-bit operands from a valid/ready
// stream, fires a 9-operand carry-save adder tree once on the buffered set,
// and returns the registered 20-bit sum over a valid/ready result stream.

// 9-operand, 16-bit carry-save adder tree with a final carry-propagate add.
module carrysaveadder916 (
    input  logic [8:0][15:0] ops,
    output logic [19:0]      sout,
    output logic             cout
);
    typedef struct packed {
        logic [19:0] c;
        logic [19:0] s;
    } csa_t;

    // 3:2 compressor over 20-bit vectors. The carry vector is shifted left;
    // nothing is lost off the top because the exact total stays below 2^20.
    function automatic csa_t csa32(input logic [19:0] a, input logic [19:0] b,
                                   input logic [19:0] c);
        csa_t r;
        r.s = a ^ b ^ c;
        r.c = ((a & b) | (a & c) | (b & c)) << 1;
        return r;
    endfunction

    function automatic logic [19:0] ext(input logic [15:0] v);
        return {4'b0000, v};
    endfunction

    csa_t l1_a, l1_b, l1_c, l2_a, l2_b, l3_a, l4_a;
    logic [20:0] final_sum;

    // Wallace reduction: 9 -> 6 -> 4 -> 3 -> 2 vectors
    assign l1_a = csa32(ext(ops[0]), ext(ops[1]), ext(ops[2]));
    assign l1_b = csa32(ext(ops[3]), ext(ops[4]), ext(ops[5]));
    assign l1_c = csa32(ext(ops[6]), ext(ops[7]), ext(ops[8]));
    assign l2_a = csa32(l1_a.s, l1_a.c, l1_b.s);
    assign l2_b = csa32(l1_b.c, l1_c.s, l1_c.c);
    assign l3_a = csa32(l2_a.s, l2_a.c, l2_b.s);
    assign l4_a = csa32(l3_a.s, l3_a.c, l2_b.c);

    // Final carry-propagate adder
    assign final_sum = {1'b0, l4_a.s} + {1'b0, l4_a.c};
    assign sout      = final_sum[19:0];
    assign cout      = final_sum[20];
endmodule

module csa916_sequencer #(
    parameter int NOPS = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        abort,
    output logic [19:0] res_sum,
    output logic        res_cout,
    output logic [3:0]  res_count,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NOPS-1:0][15:0]  op_q, op_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [19:0]            res_sum_q, res_sum_d;
    logic                   res_cout_q, res_cout_d;
    logic [3:0]             res_count_q, res_count_d;
    logic                   in_ready_q, out_valid_q, busy_q;
    logic [19:0]            sout;
    logic                   cout;

    carrysaveadder916 u_adder (
        .ops  (op_q),
        .sout (sout),
        .cout (cout)
    );

    // Next-state, operand buffer and result capture; abort overrides everything
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
        res_count_d = res_count_q;
        if (abort) begin
            state_d = COLLECT;
            op_d    = '0;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (in_valid) begin
                        for (int i = 0; i < NOPS; i++) begin
                            if (cnt_q == 4'(i)) op_d[i] = in_data;
                        end
                        cnt_d = cnt_q + 4'd1;
                        if (in_last || cnt_q == 4'd8) state_d = COMPUTE;
                    end
                end
                COMPUTE: begin
                    res_sum_d   = sout;
                    res_cout_d  = cout;
                    res_count_d = cnt_q;
                    state_d     = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        op_d    = '0;
                        cnt_d   = 4'd0;
                        state_d = COLLECT;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    // State, buffer, results and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= COLLECT;
            op_q        <= '0;
            cnt_q       <= 4'd0;
            res_sum_q   <= 20'd0;
            res_cout_q  <= 1'b0;
            res_count_q <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
            res_count_q <= res_count_d;
            in_ready_q  <= (state_d == COLLECT);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != COLLECT);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_count = res_count_q;
endmodule

// File: tb/tb_csa916_sequencer.sv
// Bench for csa916_sequencer: randomized batches checked against a
// queue-based model of accepted operands and the handshake timeline.
module tb_csa916_sequencer;
    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        abort;
    logic [19:0] res_sum;
    logic        res_cout;
    logic [3:0]  res_count;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    csa916_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .abort     (abort),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_count (res_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_deliv = 0;
    int exp_deliv = 0;

    logic [15:0] w [9];
    logic [15:0] acc [$];

    // Results actually handed over to the consumer
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready && !abort) n_deliv++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_sum();
        logic [31:0] s = 0;
        foreach (acc[i]) s += 32'(acc[i]);
        return s;
    endfunction

    task automatic fill_const(input logic [15:0] v);
        for (int i = 0; i < 9; i++) w[i] = v;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 9; i++) w[i] = 16'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_res_sum"},   32'(res_sum),   32'd0);
        chk({tag, "_res_cout"},  32'(res_cout),  32'd0);
        chk({tag, "_res_count"}, 32'(res_count), 32'd0);
    endtask

    // Present k words from w[], one per cycle; the last is accepted at the next edge
    task automatic feed_words(input int k, input bit last_on_final);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            chk("in_ready_collect", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = w[i];
            in_last  = last_on_final && (i == k - 1);
            acc.push_back(w[i]);
        end
    endtask

    // Follow COMPUTE and DONE after the final operand; optional stall or abort in DONE
    task automatic finish_batch(input int stall, input bit abort_in_done);
        logic [31:0] es;
        logic [31:0] ec;
        es = model_sum();
        ec = 32'(acc.size());
        @(negedge clk);
        in_valid  = 1'($urandom);
        in_data   = 16'($urandom);
        in_last   = 1'($urandom);
        out_ready = (stall == 0);
        chk("compute_in_ready", 32'(in_ready), 32'd0);
        chk("compute_out_valid", 32'(out_valid), 32'd0);
        chk("compute_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("done_out_valid", 32'(out_valid), 32'd1);
        chk("done_in_ready", 32'(in_ready), 32'd0);
        chk("res_sum", 32'(res_sum), es);
        chk("res_cout", 32'(res_cout), 32'd0);
        chk("res_count", 32'(res_count), ec);
        if (abort_in_done) begin
            abort     = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("abort_done_out_valid", 32'(out_valid), 32'd0);
            chk("abort_done_in_ready", 32'(in_ready), 32'd1);
        end else begin
            for (int s = 0; s < stall; s++) begin
                in_valid = 1'b1;
                in_data  = 16'($urandom);
                @(negedge clk);
                chk("stall_out_valid", 32'(out_valid), 32'd1);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                chk("stall_res_sum", 32'(res_sum), es);
                chk("stall_res_count", 32'(res_count), ec);
            end
            out_ready = 1'b1;
            exp_deliv++;
            @(negedge clk);
            chk("post_hs_out_valid", 32'(out_valid), 32'd0);
            chk("post_hs_in_ready", 32'(in_ready), 32'd1);
            chk("post_hs_busy", 32'(busy), 32'd0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'($urandom);
        acc.delete();
    endtask

    task automatic run_batch(input int k, input bit use_last, input int stall);
        feed_words(k, use_last);
        finish_batch(stall, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        abort = 1'b0; out_ready = 1'b0;
        #1 rst = 1'b1;
        #2 check_reset_vals("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Full-scale batch, back-to-back
        fill_const(16'hFFFF);
        run_batch(9, 1'b0, 0);
        // 1..9 then 9x1 to confirm the buffer is cleared
        for (int i = 0; i < 9; i++) w[i] = 16'(i + 1);
        run_batch(9, 1'b1, 0);
        fill_const(16'h0001);
        run_batch(9, 1'b0, 0);
        // Early close
        w[0] = 16'd100; w[1] = 16'd200; w[2] = 16'd300;
        run_batch(3, 1'b1, 0);
        w[0] = 16'h1234;
        run_batch(1, 1'b1, 0);
        // Backpressure in DONE with a valid word waiting
        fill_rand();
        run_batch(5, 1'b1, 5);

        // Abort after four operands, concurrent with a fifth valid word
        fill_rand();
        feed_words(4, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'hBEEF; in_last = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_collect_in_ready", 32'(in_ready), 32'd1);
        chk("abort_collect_busy", 32'(busy), 32'd0);
        chk("abort_collect_out_valid", 32'(out_valid), 32'd0);
        acc.delete();
        fill_const(16'h0002);
        run_batch(9, 1'b0, 0);

        // Abort together with out_ready in DONE
        fill_rand();
        feed_words(6, 1'b1);
        finish_batch(0, 1'b1);
        acc.delete();

        // Randomized batches
        for (int b = 0; b < 25; b++) begin
            int k;
            k = $urandom_range(1, 9);
            fill_rand();
            run_batch(k, (k < 9) ? 1'b1 : 1'($urandom), $urandom_range(0, 3));
        end

        // Asynchronous reset mid-collect
        fill_rand();
        feed_words(3, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_vals("rst_collect");
        @(negedge clk);
        rst = 1'b0;
        acc.delete();

        // Asynchronous reset during COMPUTE, after a result has been produced
        fill_rand();
        run_batch(4, 1'b1, 0);
        fill_rand();
        feed_words(5, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_vals("rst_compute");
        @(negedge clk);
        rst = 1'b0;
        acc.delete();
        fill_const(16'h1000);
        run_batch(9, 1'b0, 0);

        @(negedge clk);
        chk("delivered_count", 32'(n_deliv), 32'(exp_deliv));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
